// File: rtl/bp_pht_port_scheduler.sv
// Arbitrates a single-port PHT SRAM between an init sweep, decode lookups and an in-order
// queue of execute-side counter updates, with lookup bypass from queued updates.
module bp_pht_port_scheduler #(
  parameter int unsigned INDEX_WIDTH = 10,
  parameter int unsigned QDEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_lkp_valid,
  input  logic [INDEX_WIDTH-1:0] i_lkp_index,
  output logic                   o_lkp_ready,
  output logic                   o_lkp_rvalid,
  output logic [1:0]             o_lkp_counter,
  output logic                   o_lkp_taken,
  input  logic                   i_fb_valid,
  input  logic [INDEX_WIDTH-1:0] i_fb_index,
  input  logic [1:0]             i_fb_counter,
  input  logic                   i_fb_taken,
  output logic                   o_fb_ready,
  output logic                   o_tbl_en,
  output logic                   o_tbl_we,
  output logic [INDEX_WIDTH-1:0] o_tbl_addr,
  output logic [1:0]             o_tbl_wdata,
  input  logic [1:0]             i_tbl_rdata,
  output logic                   o_init_done
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                 state_q;
  logic                   armed_q;
  logic [INDEX_WIDTH-1:0] sweep_q;
  logic [INDEX_WIDTH-1:0] q_idx_q [QDEPTH];
  logic [1:0]             q_data_q [QDEPTH];
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic                   rvalid_q, byp_hit_q;
  logic [1:0]             byp_data_q;

  logic          run, full, empty, lkp_acc, pop, push;
  logic [PW-1:0] occ;
  logic [1:0]    fb_next;
  logic          byp_hit_d;
  logic [1:0]    byp_data_d;
  logic [AW-1:0] slot;

  assign run         = (state_q == StRun);
  assign occ         = wr_ptr_q - rd_ptr_q;
  assign full        = (occ == PW'(QDEPTH));
  assign empty       = (occ == '0);
  assign o_lkp_ready = run & ~full;
  assign o_fb_ready  = run & ~full;
  assign o_init_done = run;
  assign lkp_acc     = o_lkp_ready & i_lkp_valid;
  // A full queue steals the port from decode; otherwise writes only fill idle cycles.
  assign pop         = run & ~empty & (full | ~i_lkp_valid);
  assign push        = i_fb_valid & o_fb_ready;

  always_comb begin
    fb_next = i_fb_counter;
    if (i_fb_taken) begin
      if (i_fb_counter != 2'b11) fb_next = i_fb_counter + 2'b01;
    end else begin
      if (i_fb_counter != 2'b00) fb_next = i_fb_counter - 2'b01;
    end
  end

  always_comb begin
    o_tbl_en    = 1'b0;
    o_tbl_we    = 1'b0;
    o_tbl_addr  = '0;
    o_tbl_wdata = 2'b00;
    if (state_q == StInit) begin
      if (armed_q) begin
        o_tbl_en    = 1'b1;
        o_tbl_we    = 1'b1;
        o_tbl_addr  = sweep_q;
        o_tbl_wdata = 2'b01;
      end
    end else if (pop) begin
      o_tbl_en    = 1'b1;
      o_tbl_we    = 1'b1;
      o_tbl_addr  = q_idx_q[rd_ptr_q[AW-1:0]];
      o_tbl_wdata = q_data_q[rd_ptr_q[AW-1:0]];
    end else if (lkp_acc) begin
      o_tbl_en   = 1'b1;
      o_tbl_addr = i_lkp_index;
    end
  end

  // Scan oldest to youngest so the youngest resident match wins.
  always_comb begin
    byp_hit_d  = 1'b0;
    byp_data_d = 2'b00;
    slot       = '0;
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      slot = rd_ptr_q[AW-1:0] + AW'(i);
      if ((PW'(i) < occ) && (q_idx_q[slot] == i_lkp_index)) begin
        byp_hit_d  = 1'b1;
        byp_data_d = q_data_q[slot];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      armed_q    <= 1'b0;
      sweep_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rvalid_q   <= 1'b0;
      byp_hit_q  <= 1'b0;
      byp_data_q <= 2'b00;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        q_idx_q[i]  <= '0;
        q_data_q[i] <= 2'b00;
      end
    end else begin
      armed_q  <= 1'b1;
      rvalid_q <= lkp_acc;
      if (lkp_acc) begin
        byp_hit_q  <= byp_hit_d;
        byp_data_q <= byp_data_d;
      end
      if (state_q == StInit) begin
        if (armed_q) begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == '1) state_q <= StRun;
        end
      end else begin
        if (push) begin
          q_idx_q[wr_ptr_q[AW-1:0]]  <= i_fb_index;
          q_data_q[wr_ptr_q[AW-1:0]] <= fb_next;
          wr_ptr_q                   <= wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign o_lkp_rvalid  = rvalid_q;
  assign o_lkp_counter = rvalid_q ? (byp_hit_q ? byp_data_q : i_tbl_rdata) : 2'b00;
  assign o_lkp_taken   = o_lkp_counter[1];

endmodule

// File: tb/tb_bp_pht_port_scheduler.sv
// Directed bench for bp_pht_port_scheduler with a behavioural single-port SRAM (16 entries).
module tb_bp_pht_port_scheduler;

  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lkp_valid;
  logic [IW-1:0] lkp_index;
  logic          lkp_ready, lkp_rvalid, lkp_taken;
  logic [1:0]    lkp_counter;
  logic          fb_valid;
  logic [IW-1:0] fb_index;
  logic [1:0]    fb_counter;
  logic          fb_taken;
  logic          fb_ready;
  logic          tbl_en, tbl_we;
  logic [IW-1:0] tbl_addr;
  logic [1:0]    tbl_wdata;
  logic [1:0]    tbl_rdata = 2'b00;
  logic          init_done;
  logic [1:0]    mem [16];

  int errors = 0;
  int checks = 0;

  bp_pht_port_scheduler #(.INDEX_WIDTH(IW), .QDEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_lkp_valid  (lkp_valid),
    .i_lkp_index  (lkp_index),
    .o_lkp_ready  (lkp_ready),
    .o_lkp_rvalid (lkp_rvalid),
    .o_lkp_counter(lkp_counter),
    .o_lkp_taken  (lkp_taken),
    .i_fb_valid   (fb_valid),
    .i_fb_index   (fb_index),
    .i_fb_counter (fb_counter),
    .i_fb_taken   (fb_taken),
    .o_fb_ready   (fb_ready),
    .o_tbl_en     (tbl_en),
    .o_tbl_we     (tbl_we),
    .o_tbl_addr   (tbl_addr),
    .o_tbl_wdata  (tbl_wdata),
    .i_tbl_rdata  (tbl_rdata),
    .o_init_done  (init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else        tbl_rdata     <= mem[tbl_addr];
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lkp_valid  = 1'b0;
    lkp_index  = '0;
    fb_valid   = 1'b0;
    fb_index   = '0;
    fb_counter = 2'b00;
    fb_taken   = 1'b0;
  endtask

  task automatic push(input int idx, input int c, input bit t);
    fb_valid   = 1'b1;
    fb_index   = IW'(idx);
    fb_counter = 2'(c);
    fb_taken   = t;
  endtask

  // Waits out the 16-entry sweep, checking every init write and the ready outputs.
  task automatic check_sweep(input string tag);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({tbl_en, tbl_we, tbl_addr, tbl_wdata, lkp_ready, fb_ready, init_done}
          !== {1'b1, 1'b1, IW'(k), 2'b01, 3'b000}) begin
        errors++;
        $display("FAIL %s sweep[%0d]: en=%b we=%b addr=%0d wd=%b rdy=%b/%b done=%b, want write %0d of 01",
                 tag, k, tbl_en, tbl_we, tbl_addr, tbl_wdata, lkp_ready, fb_ready, init_done, k);
      end
      cyc();
    end
    checks++;
    if ({init_done, lkp_ready, fb_ready, tbl_en} !== 4'b1110) begin
      errors++;
      $display("FAIL %s run_entry: done=%b lrdy=%b frdy=%b en=%b, want 1 1 1 0",
               tag, init_done, lkp_ready, fb_ready, tbl_en);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) cyc();
    checks++;
    if ({tbl_en, tbl_we, lkp_ready, fb_ready, init_done, lkp_rvalid, lkp_counter} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want 00000000",
               {tbl_en, tbl_we, lkp_ready, fb_ready, init_done, lkp_rvalid, lkp_counter});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (tbl_en !== 1'b0) begin
      errors++;
      $display("FAIL release_no_write: en=%b, want 0", tbl_en);
    end
    cyc();
    check_sweep("init");
  endtask

  task automatic test_fb_update();
    int idx_v [5] = '{5, 6, 9, 8, 11};
    int c_v   [5] = '{1, 3, 0, 2, 0};
    bit t_v   [5] = '{1, 1, 0, 0, 1};
    int exp_v [5] = '{2, 3, 0, 1, 1};
    for (int i = 0; i < 5; i++) begin
      push(idx_v[i], c_v[i], t_v[i]);
      #1;
      checks++;
      if (fb_ready !== 1'b1 || tbl_en !== 1'b0) begin
        errors++;
        $display("FAIL fb_push[%0d]: ready=%b en=%b, want 1 0", i, fb_ready, tbl_en);
      end
      cyc();
      idle_inputs();
      #1;
      checks++;
      if ({tbl_en, tbl_we, tbl_addr, tbl_wdata} !== {2'b11, IW'(idx_v[i]), 2'(exp_v[i])}) begin
        errors++;
        $display("FAIL fb_write[%0d]: en=%b we=%b addr=%0d wd=%b, want write %0d data %0d",
                 i, tbl_en, tbl_we, tbl_addr, tbl_wdata, idx_v[i], exp_v[i]);
      end
      cyc();
    end
  endtask

  task automatic test_lookup();
    int idx_v [3] = '{5, 6, 9};
    int exp_v [3] = '{2, 3, 0};
    for (int i = 0; i < 3; i++) begin
      lkp_valid = 1'b1;
      lkp_index = IW'(idx_v[i]);
      #1;
      checks++;
      if ({lkp_ready, tbl_en, tbl_we, tbl_addr} !== {3'b110, IW'(idx_v[i])}) begin
        errors++;
        $display("FAIL lkp_issue[%0d]: rdy=%b en=%b we=%b addr=%0d, want read %0d",
                 i, lkp_ready, tbl_en, tbl_we, tbl_addr, idx_v[i]);
      end
      cyc();
      idle_inputs();
      #1;
      checks++;
      if ({lkp_rvalid, lkp_counter, lkp_taken} !== {1'b1, 2'(exp_v[i]), exp_v[i] >= 2}) begin
        errors++;
        $display("FAIL lkp_resp[%0d]: rvalid=%b ctr=%b taken=%b, want 1 %0d",
                 i, lkp_rvalid, lkp_counter, lkp_taken, exp_v[i]);
      end
      cyc();
    end
  endtask

  task automatic test_bypass();
    lkp_valid = 1'b1;
    lkp_index = 4'd2;
    push(7, 1, 1'b1);
    #1;
    checks++;
    if ({lkp_ready, tbl_en, tbl_we, tbl_addr} !== {3'b110, 4'd2}) begin
      errors++;
      $display("FAIL byp_issue: rdy=%b en=%b we=%b addr=%0d, want read 2",
               lkp_ready, tbl_en, tbl_we, tbl_addr);
    end
    cyc();
    idle_inputs();
    lkp_valid = 1'b1;
    lkp_index = 4'd7;
    #1;
    checks++;
    if ({lkp_rvalid, lkp_counter, tbl_en, tbl_we, tbl_addr} !== {3'b101, 2'b10, 4'd7}) begin
      errors++;
      $display("FAIL byp_sram_path: rvalid=%b ctr=%b en=%b we=%b addr=%0d, want 1 01 read 7",
               lkp_rvalid, lkp_counter, tbl_en, tbl_we, tbl_addr);
    end
    cyc();
    idle_inputs();
    #1;
    checks++;
    if ({lkp_rvalid, lkp_counter, lkp_taken} !== 4'b1101) begin
      errors++;
      $display("FAIL byp_hit: rvalid=%b ctr=%b taken=%b, want 1 10 1",
               lkp_rvalid, lkp_counter, lkp_taken);
    end
    checks++;
    if ({tbl_en, tbl_we, tbl_addr, tbl_wdata} !== {2'b11, 4'd7, 2'b10}) begin
      errors++;
      $display("FAIL byp_drain: en=%b we=%b addr=%0d wd=%b, want write 7 data 10",
               tbl_en, tbl_we, tbl_addr, tbl_wdata);
    end
    cyc();
  endtask

  task automatic test_youngest();
    lkp_valid = 1'b1;
    lkp_index = 4'd0;
    push(3, 0, 1'b1);
    cyc();
    push(3, 2, 1'b1);
    cyc();
    fb_valid  = 1'b0;
    lkp_index = 4'd3;
    cyc();
    idle_inputs();
    #1;
    checks++;
    if ({lkp_rvalid, lkp_counter} !== 3'b111) begin
      errors++;
      $display("FAIL youngest_hit: rvalid=%b ctr=%b, want 1 11", lkp_rvalid, lkp_counter);
    end
    checks++;
    if ({tbl_en, tbl_we, tbl_addr, tbl_wdata} !== {2'b11, 4'd3, 2'b01}) begin
      errors++;
      $display("FAIL youngest_w0: en=%b we=%b addr=%0d wd=%b, want write 3 data 01",
               tbl_en, tbl_we, tbl_addr, tbl_wdata);
    end
    cyc();
    checks++;
    if ({tbl_en, tbl_we, tbl_addr, tbl_wdata} !== {2'b11, 4'd3, 2'b11}) begin
      errors++;
      $display("FAIL youngest_w1: en=%b we=%b addr=%0d wd=%b, want write 3 data 11",
               tbl_en, tbl_we, tbl_addr, tbl_wdata);
    end
    cyc();
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      lkp_valid = 1'b1;
      lkp_index = 4'd0;
      push(10 + k, 2, 1'b1);
      #1;
      checks++;
      if ({fb_ready, lkp_ready, tbl_en, tbl_we} !== 4'b1110) begin
        errors++;
        $display("FAIL fill[%0d]: frdy=%b lrdy=%b en=%b we=%b, want 1 1 1 0",
                 k, fb_ready, lkp_ready, tbl_en, tbl_we);
      end
      cyc();
    end
    push(14, 2, 1'b1);
    #1;
    checks++;
    if ({fb_ready, lkp_ready} !== 2'b00) begin
      errors++;
      $display("FAIL full_ready: frdy=%b lrdy=%b, want 0 0", fb_ready, lkp_ready);
    end
    checks++;
    if ({tbl_en, tbl_we, tbl_addr, tbl_wdata} !== {2'b11, 4'd10, 2'b11}) begin
      errors++;
      $display("FAIL full_write: en=%b we=%b addr=%0d wd=%b, want write 10 data 11",
               tbl_en, tbl_we, tbl_addr, tbl_wdata);
    end
    cyc();
    fb_valid = 1'b0;
    #1;
    checks++;
    if ({fb_ready, lkp_ready, lkp_rvalid, tbl_en, tbl_we, tbl_addr} !== {5'b11010, 4'd0}) begin
      errors++;
      $display("FAIL after_full: frdy=%b lrdy=%b rvalid=%b en=%b we=%b addr=%0d, want 1 1 0 read 0",
               fb_ready, lkp_ready, lkp_rvalid, tbl_en, tbl_we, tbl_addr);
    end
    cyc();
    idle_inputs();
    for (int k = 1; k < 4; k++) begin
      #1;
      checks++;
      if ({tbl_en, tbl_we, tbl_addr, tbl_wdata} !== {2'b11, IW'(10 + k), 2'b11}) begin
        errors++;
        $display("FAIL drain[%0d]: en=%b we=%b addr=%0d wd=%b, want write %0d data 11",
                 k, tbl_en, tbl_we, tbl_addr, tbl_wdata, 10 + k);
      end
      cyc();
    end
    checks++;
    if (tbl_en !== 1'b0) begin
      errors++;
      $display("FAIL dropped_push: en=%b addr=%0d, want idle", tbl_en, tbl_addr);
    end
  endtask

  task automatic test_reset_mid_run();
    for (int k = 0; k < 3; k++) begin
      lkp_valid = 1'b1;
      lkp_index = 4'd1;
      push(4 + k, 1, 1'b1);
      cyc();
    end
    idle_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tbl_en, tbl_we, tbl_addr, tbl_wdata, lkp_ready, fb_ready, init_done, lkp_rvalid,
         lkp_counter} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: en=%b we=%b addr=%0d wd=%b rdy=%b/%b done=%b rv=%b ctr=%b, want 0",
               tbl_en, tbl_we, tbl_addr, tbl_wdata, lkp_ready, fb_ready, init_done, lkp_rvalid,
               lkp_counter);
    end
    repeat (2) cyc();
    rst_n = 1'b1;
    #1;
    checks++;
    if (tbl_en !== 1'b0) begin
      errors++;
      $display("FAIL midrun_release: en=%b, want 0", tbl_en);
    end
    cyc();
    check_sweep("resweep");
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if ({tbl_en, lkp_rvalid} !== 2'b00) begin
        errors++;
        $display("FAIL stale_write[%0d]: en=%b addr=%0d rv=%b, want idle", k, tbl_en, tbl_addr,
                 lkp_rvalid);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 2'b00;
    test_reset();
    test_fb_update();
    test_lookup();
    test_bypass();
    test_youngest();
    test_full();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
